// File: rtl/spi_word_sequencer.sv
// SPI word sequencer: buffers outgoing words in a small TX FIFO and feeds
// them one at a time to an SPI master (newd/din), then waits for the slave's
// done edge to capture the returned word, abandoning the word on timeout.
module spi_word_sequencer #(
    parameter int WIDTH   = 12,
    parameter int DEPTH   = 4,
    parameter int HOLD    = 24,
    parameter int TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       newd,
    output logic [WIDTH-1:0]           din,
    input  logic [WIDTH-1:0]           dout,
    input  logic                       done,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       rx_valid,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = $clog2(HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [HW-1:0]      hold_cnt_r;
    logic [TW-1:0]      to_cnt_r;
    logic               done_q_r;
    logic               newd_r;
    logic [WIDTH-1:0]   din_r;
    logic [WIDTH-1:0]   rx_data_r;
    logic               rx_valid_r;
    logic               busy_r;
    logic               timeout_err_r;

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic               done_edge_s;

    // Occupancy flags come from the count, so a wrapped pointer pair is unambiguous.
    assign full_s      = (count_r == CW'(DEPTH));
    assign empty_s     = (count_r == CW'(0));
    // A push while full is dropped even if a pop happens the same cycle.
    assign push_s      = wr_en & ~full_s;
    // The head word leaves the FIFO during the single LOAD cycle.
    assign pop_s       = (state_r == ST_LOAD);
    assign done_edge_s = done & ~done_q_r;

    // TX FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Transfer sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            hold_cnt_r    <= HW'(0);
            to_cnt_r      <= TW'(0);
            done_q_r      <= 1'b0;
            newd_r        <= 1'b0;
            din_r         <= WIDTH'(0);
            rx_data_r     <= WIDTH'(0);
            rx_valid_r    <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            done_q_r   <= done;
            rx_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    din_r      <= mem_r[rd_ptr_r];
                    newd_r     <= 1'b1;
                    hold_cnt_r <= HW'(0);
                    state_r    <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // Done edges here are ignored; the slave cannot have finished yet.
                    if (hold_cnt_r == HW'(HOLD - 1)) begin
                        newd_r     <= 1'b0;
                        hold_cnt_r <= HW'(0);
                        to_cnt_r   <= TW'(0);
                        state_r    <= ST_WAIT;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end
                end
                ST_WAIT: begin
                    if (done_edge_s) begin
                        rx_data_r  <= dout;
                        rx_valid_r <= 1'b1;
                        state_r    <= ST_GAP;
                    end else if (to_cnt_r == TW'(TIMEOUT - 1)) begin
                        timeout_err_r <= 1'b1;
                        state_r       <= ST_GAP;
                    end else begin
                        to_cnt_r <= to_cnt_r + TW'(1);
                    end
                end
                ST_GAP: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    newd_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign full        = full_s;
    assign empty       = empty_s;
    assign count       = count_r;
    assign newd        = newd_r;
    assign din         = din_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_spi_word_sequencer.sv
// Directed bench for spi_word_sequencer with default parameters.
module tb_spi_word_sequencer;

    localparam int WIDTH   = 12;
    localparam int DEPTH   = 4;
    localparam int HOLD    = 24;
    localparam int TIMEOUT = 1023;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_en;
    logic [WIDTH-1:0]   wr_data;
    logic               full;
    logic               empty;
    logic [2:0]         count;
    logic               newd;
    logic [WIDTH-1:0]   din;
    logic [WIDTH-1:0]   dout;
    logic               done;
    logic [WIDTH-1:0]   rx_data;
    logic               rx_valid;
    logic               busy;
    logic               timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    spi_word_sequencer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .newd(newd), .din(din),
        .dout(dout), .done(done), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for a word to be issued, check it, let the slave answer, check the capture.
    task automatic xfer(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] ret);
        for (int n = 0; n < 50 && !newd; n++) tick();
        chk("newd_rise", 32'(newd), 32'd1);
        chk("din_word", 32'(din), 32'(w));
        for (int n = 0; n < 50 && newd; n++) tick();
        chk("newd_fall", 32'(newd), 32'd0);
        repeat (3) tick();
        dout = ret;
        done = 1'b1;
        tick();
        chk("rx_valid_pulse", 32'(rx_valid), 32'd1);
        chk("rx_data_word", 32'(rx_data), 32'(ret));
        done = 1'b0;
        tick();
        chk("rx_valid_drop", 32'(rx_valid), 32'd0);
    endtask

    initial begin
        int hi;
        int seen;

        // Reset with wr_en held high.
        rst = 1'b1; wr_en = 1'b1; wr_data = 12'h777; dout = 12'h000; done = 1'b0;
        repeat (5) tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_newd", 32'(newd), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0; wr_en = 1'b0;
        tick();
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Single word, 3-cycle latency, HOLD-cycle strobe, done 40 cycles after fall.
        wr_en = 1'b1; wr_data = 12'hA5C;
        tick();
        wr_en = 1'b0;
        chk("single_count1", 32'(count), 32'd1);
        chk("single_newd_e0", 32'(newd), 32'd0);
        tick();
        chk("single_busy_load", 32'(busy), 32'd1);
        chk("single_newd_e1", 32'(newd), 32'd0);
        tick();
        chk("single_newd_e2", 32'(newd), 32'd1);
        chk("single_din", 32'(din), 32'hA5C);
        chk("single_count0", 32'(count), 32'd0);
        hi = 0;
        while (newd && hi < 100) begin
            hi++;
            tick();
        end
        chk("single_hold_len", 32'(hi), 32'(HOLD));
        chk("single_din_stable", 32'(din), 32'hA5C);
        seen = 0;
        repeat (39) begin
            tick();
            if (rx_valid) seen++;
        end
        chk("single_no_early_rx", 32'(seen), 32'd0);
        dout = 12'hA5C; done = 1'b1;
        tick();
        chk("single_rx_valid", 32'(rx_valid), 32'd1);
        chk("single_rx_data", 32'(rx_data), 32'hA5C);
        chk("single_busy_gap", 32'(busy), 32'd1);
        tick();
        chk("single_rx_once", 32'(rx_valid), 32'd0);
        chk("single_busy_low", 32'(busy), 32'd0);
        done = 1'b0;
        tick();
        chk("single_no_timeout", 32'(timeout_err), 32'd0);

        // Overflow: six back-to-back pushes, sixth dropped.
        for (int i = 1; i <= 6; i++) begin
            wr_en = 1'b1; wr_data = WIDTH'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        for (int i = 1; i <= 5; i++) xfer(WIDTH'(i), WIDTH'(i + 16));
        seen = 0;
        repeat (10) begin
            tick();
            if (newd) seen++;
        end
        chk("ovf_word6_dropped", 32'(seen), 32'd0);
        chk("ovf_empty", 32'(empty), 32'd1);

        // Push in the same cycle as LOAD with two words held.
        wr_en = 1'b1; wr_data = 12'h111; tick();
        wr_data = 12'h222; tick();
        chk("simul_count_pre", 32'(count), 32'd2);
        wr_data = 12'h333; tick();
        wr_en = 1'b0;
        chk("simul_count_kept", 32'(count), 32'd2);
        chk("simul_newd", 32'(newd), 32'd1);
        xfer(12'h111, 12'hABC);
        xfer(12'h222, 12'hBCD);
        xfer(12'h333, 12'hCDE);

        // Timeout: no done for the first word, second word still goes out.
        wr_en = 1'b1; wr_data = 12'h0F0; tick();
        wr_data = 12'h0E1; tick();
        wr_en = 1'b0;
        for (int n = 0; n < 50 && !newd; n++) tick();
        chk("to_newd_rise", 32'(newd), 32'd1);
        for (int n = 0; n < 50 && newd; n++) tick();
        chk("to_newd_fall", 32'(newd), 32'd0);
        seen = 0;
        repeat (TIMEOUT - 1) begin
            tick();
            if (rx_valid) seen++;
        end
        chk("to_not_yet", 32'(timeout_err), 32'd0);
        tick();
        chk("to_set", 32'(timeout_err), 32'd1);
        chk("to_no_rx_valid", 32'(seen + int'(rx_valid)), 32'd0);
        xfer(12'h0E1, 12'h5A5);
        chk("to_sticky", 32'(timeout_err), 32'd1);

        // Reset in WAIT with three words queued; a late done is ignored.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = WIDTH'(12'h400 + i);
            tick();
        end
        wr_en = 1'b0;
        for (int n = 0; n < 50 && !newd; n++) tick();
        for (int n = 0; n < 50 && newd; n++) tick();
        chk("mid_count3", 32'(count), 32'd3);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_newd", 32'(newd), 32'd0);
        chk("mid_count0", 32'(count), 32'd0);
        chk("mid_busy0", 32'(busy), 32'd0);
        chk("mid_timeout_clr", 32'(timeout_err), 32'd0);
        tick();
        dout = 12'hFFF; done = 1'b1;
        tick();
        chk("mid_late_done", 32'(rx_valid), 32'd0);
        done = 1'b0;
        seen = 0;
        repeat (10) begin
            tick();
            if (newd || busy) seen++;
        end
        chk("mid_stays_idle", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_word_sequencer.md
SPI_WORD_SEQUENCER -- requirements
Module: spi_word_sequencer

Interface
REQ-001 Parameter WIDTH, default 12: data word width, matches the SPI master din/dout width.
REQ-002 Parameter DEPTH, default 4: TX FIFO depth in words, power of two, minimum 2.
REQ-003 Parameter HOLD, default 24: number of clk cycles newd is held high per word, at least one SPI sclk period.
REQ-004 Parameter TIMEOUT, default 1023: maximum clk cycles allowed from end of newd to done before the word is abandoned.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  push wr_data into the TX FIFO this cycle.
REQ-008 wr_data  in  WIDTH  word to transmit.
REQ-009 full  out  1  FIFO holds DEPTH words.
REQ-010 empty  out  1  FIFO holds 0 words.
REQ-011 count  out  clog2(DEPTH)+1  FIFO occupancy.
REQ-012 newd  out  1  new-data strobe to the SPI master.
REQ-013 din  out  WIDTH  word presented to the SPI master.
REQ-014 dout  in  WIDTH  word received by the SPI slave.
REQ-015 done  in  1  slave receive-complete indication (level or pulse).
REQ-016 rx_data  out  WIDTH  last captured dout.
REQ-017 rx_valid  out  1  one-cycle pulse: rx_data updated.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 timeout_err  out  1  sticky flag set on timeout; cleared only by rst.

Function
REQ-020 FIFO: a push with wr_en=1 and full=0 stores wr_data at the tail; wr_en=1 with full=1 drops the word and leaves FIFO contents unchanged.
REQ-021 A push and a pop in the same cycle (FIFO not full) leave count unchanged, and both operations take effect.
REQ-022 Read and write pointers wrap modulo DEPTH; full and empty derive from count, not from pointer equality alone.
REQ-023 The FSM states are IDLE, LOAD, ISSUE, WAIT, and GAP.
REQ-024 IDLE -> LOAD when empty=0; LOAD pops the head word into din (count decrements on that cycle).
REQ-025 LOAD -> ISSUE next cycle; ISSUE drives newd=1 for exactly HOLD cycles, with din stable, then drives newd=0 and goes to WAIT.
REQ-026 The block detects done as a rising edge, done=1 with the previous-cycle done=0; a done edge seen during ISSUE is ignored.
REQ-027 WAIT: on a done rising edge, rx_data is set to dout and rx_valid pulses for 1 cycle; the FSM then goes to GAP.
REQ-028 WAIT: if TIMEOUT cycles elapse without a done edge, timeout_err is set, no rx_valid is produced, and the FSM goes to GAP.
REQ-029 GAP lasts 1 cycle, then returns to IDLE; back-to-back words therefore start 2 cycles after completion.
REQ-030 din holds its last value outside ISSUE and WAIT; newd is 0 in every state except ISSUE.
REQ-031 Latency from a push into an empty idle FIFO to newd=1 is 3 cycles: the push edge, then IDLE->LOAD, then LOAD->ISSUE.
REQ-032 Pushes are accepted in every FSM state; the word being transferred no longer occupies FIFO space.

Reset
REQ-033 With rst=1 at a clk edge: FSM=IDLE, pointers=0, count=0, empty=1, full=0, newd=0, din=0, rx_data=0, rx_valid=0, busy=0, timeout_err=0, HOLD and TIMEOUT counters=0, done edge register=0.
REQ-034 Reset mid-transfer discards the in-flight word and all FIFO contents, and drops newd on the same edge.
REQ-035 wr_en is ignored in any cycle where rst=1.

Verification
REQ-036 Reset: hold rst for 5 cycles with wr_en=1 -> all outputs at their REQ-033 values and count=0 after release.
REQ-037 Single word: push 12'hA5C; the SPI model returns dout=12'hA5C with done 40 cycles after newd falls -> newd high for 24 cycles starting 3 cycles after the push, rx_data=12'hA5C, 1 rx_valid pulse, busy low 2 cycles later.
REQ-038 Full/overflow: with the model stalled, push 6 words 1..6 -> the first word goes into flight, words 2..5 fill the FIFO (full=1, count=4), word 6 is dropped; transmitted order is 1,2,3,4,5.
REQ-039 Simultaneous push and pop: push in the same cycle as LOAD with count=2 -> count stays 2 and no word is lost.
REQ-040 Timeout: done is never asserted -> timeout_err=1 exactly TIMEOUT cycles after newd falls, no rx_valid, and the next FIFO word is still issued.
REQ-041 Reset mid-WAIT with 3 words queued -> next cycle newd=0, count=0, IDLE; a late done edge produces no rx_valid.
